axis_bram_adapter_m_axis_pkt: RTL and testbench

Parametrised successor to the M00 AXI-Stream master of the BRAM adapter. It accepts words from the BRAM read buffer over a valid/accept handshake, holds them in an internal FIFO of configurable depth, and drives an AXI4-Stream master port. TLAST is either passed through from the buffer or generated internally from a runtime packet length. Sits between the BRAM read sequencer and the downstream AXIS fabric.

---
 rtl/axis_bram_adapter_m_axis_pkt.sv | 114 +++++++++++
 tb/tb_axis_bram_adapter_m_axis_pkt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_m_axis_pkt.sv
// AXI4-Stream master for the BRAM adapter: buffers words from the BRAM read
// buffer in a first-word-fall-through FIFO and drives the stream port.
// TLAST comes from DIN_LAST, or in mode 1 is also generated from PKT_LEN.
module axis_bram_adapter_m_axis_pkt #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_FIFO_DEPTH         = 16,
  parameter int unsigned C_TLAST_MODE         = 1,
  parameter int unsigned C_PKT_LEN_WIDTH      = 16
) (
  input  logic                                  M_AXIS_ACLK,
  input  logic                                  M_AXIS_ARESETN,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]       DIN_FROM_BUF,
  input  logic                                  DIN_VALID,
  input  logic                                  DIN_LAST,
  output logic                                  DIN_ACCEP,
  input  logic [C_PKT_LEN_WIDTH-1:0]            PKT_LEN,
  output logic [$clog2(C_FIFO_DEPTH):0]         FIFO_LEVEL,
  output logic                                  PKT_SENT,
  output logic                                  M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0]   M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  input  logic                                  M_AXIS_TREADY
);

  localparam int unsigned W  = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = C_PKT_LEN_WIDTH;

  logic [W:0]    mem_q [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          accep_q;
  logic [PW-1:0] beat_cnt_q, beat_cnt_d;
  logic [PW-1:0] pkt_len_q, pkt_len_d;
  logic [PW-1:0] cur_len;
  logic          pkt_sent_q;
  logic          wr_en, rd_en, last_flag, tvalid;
  logic [W:0]    head;

  assign tvalid = (level_q != '0);
  assign wr_en  = DIN_VALID & accep_q;
  assign rd_en  = tvalid & M_AXIS_TREADY;
  assign head   = mem_q[rd_ptr_q];

  // Packet framing: the first beat of a packet uses PKT_LEN directly and
  // latches it, so later beats of the same packet ignore PKT_LEN changes.
  always_comb begin
    cur_len    = (beat_cnt_q == '0) ? PKT_LEN : pkt_len_q;
    last_flag  = DIN_LAST;
    if (C_TLAST_MODE != 0) begin
      last_flag = DIN_LAST | (cur_len == '0) | (beat_cnt_q == (cur_len - PW'(1)));
    end
    beat_cnt_d = beat_cnt_q;
    pkt_len_d  = pkt_len_q;
    if (wr_en) begin
      if (beat_cnt_q == '0) begin
        pkt_len_d = PKT_LEN;
      end
      beat_cnt_d = last_flag ? '0 : beat_cnt_q + PW'(1);
    end
  end

  // Pointer and occupancy next-state; pointers wrap naturally at the depth.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage of {last_flag, data}; contents need no reset.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {last_flag, DIN_FROM_BUF};
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      accep_q    <= 1'b0;
      beat_cnt_q <= '0;
      pkt_len_q  <= '0;
      pkt_sent_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      accep_q    <= (level_d < LW'(C_FIFO_DEPTH));
      beat_cnt_q <= beat_cnt_d;
      pkt_len_q  <= pkt_len_d;
      pkt_sent_q <= rd_en & head[W];
    end
  end

  assign DIN_ACCEP     = accep_q;
  assign FIFO_LEVEL    = level_q;
  assign PKT_SENT      = pkt_sent_q;
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? head[W-1:0] : '0;
  assign M_AXIS_TLAST  = tvalid & head[W];
  assign M_AXIS_TSTRB  = {(W/8){tvalid}};

endmodule

// File: tb/tb_axis_bram_adapter_m_axis_pkt.sv
// Scoreboard bench: two instances (TLAST mode 1 and mode 0) share stimulus;
// expected beats are queued at acceptance and checked by a stream monitor.
module tb_axis_bram_adapter_m_axis_pkt;
  localparam int W  = 32;
  localparam int PW = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          dvalid, dlast, tready;
  logic [PW-1:0] pkt_len;

  logic          accep1, sent1, tvalid1, tlast1;
  logic [LW-1:0] level1;
  logic [W-1:0]  tdata1;
  logic [3:0]    tstrb1;
  logic          accep0, sent0, tvalid0, tlast0;
  logic [LW-1:0] level0;
  logic [W-1:0]  tdata0;
  logic [3:0]    tstrb0;

  int checks = 0;
  int errors = 0;
  int sent1_cnt = 0;
  logic [W:0] q1[$];
  logic [W:0] q0[$];
  logic prev1 = 1'b0, prev0 = 1'b0;
  logic stall1 = 1'b0;
  logic [W:0] held1 = '0;
  logic done;

  always #5 clk = ~clk;

  axis_bram_adapter_m_axis_pkt #(
    .C_M_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(16), .C_TLAST_MODE(1), .C_PKT_LEN_WIDTH(PW)
  ) u_m1 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .DIN_FROM_BUF(din), .DIN_VALID(dvalid),
    .DIN_LAST(dlast), .DIN_ACCEP(accep1), .PKT_LEN(pkt_len), .FIFO_LEVEL(level1),
    .PKT_SENT(sent1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TDATA(tdata1),
    .M_AXIS_TSTRB(tstrb1), .M_AXIS_TLAST(tlast1), .M_AXIS_TREADY(tready)
  );

  axis_bram_adapter_m_axis_pkt #(
    .C_M_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(16), .C_TLAST_MODE(0), .C_PKT_LEN_WIDTH(PW)
  ) u_m0 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .DIN_FROM_BUF(din), .DIN_VALID(dvalid),
    .DIN_LAST(dlast), .DIN_ACCEP(accep0), .PKT_LEN(pkt_len), .FIFO_LEVEL(level0),
    .PKT_SENT(sent0), .M_AXIS_TVALID(tvalid0), .M_AXIS_TDATA(tdata0),
    .M_AXIS_TSTRB(tstrb0), .M_AXIS_TLAST(tlast0), .M_AXIS_TREADY(tready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one word; queue expected {tlast, data} for each instance once accepted.
  task automatic send(input logic [W-1:0] d, input logic l, input logic exp1);
    int n;
    din = d; dlast = l; dvalid = 1'b1; n = 0;
    while (!accep1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 64'(accep1), 64'(1));
    if (accep1) begin
      q0.push_back({l, d});
      q1.push_back({exp1, d});
      @(posedge clk); #1;
    end
    dvalid = 1'b0; dlast = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 64'(q1.size() + q0.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("idle_tvalid", 64'({tvalid1, tvalid0}), 64'(0));
  endtask

  // Stream monitor: beats, strobes, stall stability and PKT_SENT timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev1 = 1'b0; prev0 = 1'b0; stall1 = 1'b0;
    end else begin
      check("pkt_sent_m1", 64'(sent1), 64'(prev1));
      check("pkt_sent_m0", 64'(sent0), 64'(prev0));
      if (sent1) sent1_cnt++;
      if (stall1) check("stall_hold", 64'({tvalid1, tlast1, tdata1}), 64'({1'b1, held1}));
      prev1  = tvalid1 && tready && tlast1;
      prev0  = tvalid0 && tready && tlast0;
      stall1 = tvalid1 && !tready;
      held1  = {tlast1, tdata1};
      if (tvalid1) check("tstrb_m1", 64'(tstrb1), 64'(4'hF));
      else         check("tstrb_idle_m1", 64'(tstrb1), 64'(0));
      if (tvalid1 && tready) begin
        if (q1.size() == 0) check("unexpected_beat_m1", 64'({tlast1, tdata1}), 64'(0));
        else check("beat_m1", 64'({tlast1, tdata1}), 64'(q1.pop_front()));
      end
      if (tvalid0 && tready) begin
        if (q0.size() == 0) check("unexpected_beat_m0", 64'({tlast0, tdata0}), 64'(0));
        else check("beat_m0", 64'({tlast0, tdata0}), 64'(q0.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; din = '0; dvalid = 1'b0; dlast = 1'b0; tready = 1'b0; pkt_len = 16'd4;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_accep", 64'({accep1, accep0}), 64'(0));
    check("rst_tvalid", 64'({tvalid1, tvalid0}), 64'(0));
    check("rst_level", 64'(level1), 64'(0));
    check("rst_tdata", 64'(tdata1), 64'(0));
    check("rst_tlast_tstrb_sent", 64'({tlast1, tstrb1, sent1}), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_accep", 64'({accep1, accep0}), 64'(2'b11));
    check("post_rst_idle", 64'({tvalid1, level1}), 64'(0));

    // Asynchronous reset with words buffered.
    for (int i = 0; i < 3; i++) send(32'hA0 + 32'(i), 1'b0, 1'b0);
    check("buffered_level", 64'(level1), 64'(3));
    check("buffered_tvalid", 64'(tvalid1), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 64'({tvalid1, tvalid0}), 64'(0));
    check("async_rst_level", 64'({level1, level0}), 64'(0));
    q1.delete(); q0.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // PKT_LEN=4, data 0..7 streaming.
    tready = 1'b1;
    base = sent1_cnt;
    for (int i = 0; i < 8; i++) send(32'(i), 1'b0, (i % 4) == 3);
    drain();
    check("pkt_sent_count", 64'(sent1_cnt - base), 64'(2));

    // DIN_LAST on the 2nd word shortens the packet; next packet runs 4 beats.
    send(32'h30, 1'b0, 1'b0); send(32'h31, 1'b1, 1'b1);
    send(32'h32, 1'b0, 1'b0); send(32'h33, 1'b0, 1'b0);
    send(32'h34, 1'b0, 1'b0); send(32'h35, 1'b0, 1'b1);
    drain();

    // PKT_LEN=0: every beat is last in mode 1.
    pkt_len = 16'd0;
    for (int i = 0; i < 3; i++) send(32'h40 + 32'(i), 1'b0, 1'b1);
    drain();

    // PKT_LEN changed mid-packet takes effect on the next packet.
    pkt_len = 16'd4;
    send(32'h50, 1'b0, 1'b0);
    pkt_len = 16'd2;
    send(32'h51, 1'b0, 1'b0); send(32'h52, 1'b0, 1'b0); send(32'h53, 1'b0, 1'b1);
    send(32'h54, 1'b0, 1'b0); send(32'h55, 1'b0, 1'b1);
    drain();

    // Backpressure: 20 words into a 16-deep FIFO.
    pkt_len = 16'd4;
    tready  = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(32'd100 + 32'(i), 1'b0, (i % 4) == 3);
      end
      begin
        int n;
        n = 0;
        while (level1 != 5'd16 && n < 100) begin
          @(posedge clk); #1;
          n++;
        end
        check("full_level", 64'(level1), 64'(16));
        check("full_accep", 64'({accep1, accep0}), 64'(0));
        check("full_head", 64'(tdata1), 64'(100));
        repeat (5) @(posedge clk);
        #1;
        check("full_hold", 64'({tvalid1, tdata1, level1}), 64'({1'b1, 32'd100, 5'd16}));
        tready = 1'b1;
      end
    join
    drain();

    // Random valid/ready; DIN_LAST every 7th word (1001 words = 143 packets).
    pkt_len = 16'd100;
    fork
      begin
        for (int i = 0; i < 1001; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(32'(i) ^ 32'h5A5A_0000, (i % 7) == 6, (i % 7) == 6);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
